// File: rtl/quad_encoder_sim_if.sv
// Control and observation bundle of the quadrature encoder simulator.
// The master drives run control; the slave (the simulator) drives the encoder lines.
interface quad_encoder_sim_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
);
  logic             Start;
  logic             Stop;
  logic             Continuous;
  logic             Dir;
  logic [DIV_W-1:0] Div;
  logic             Aout;
  logic             Bout;
  logic             Zout;
  logic             Busy;
  logic [CNT_W-1:0] Pos;
  logic             RevDone;

  modport master (
    output Start, Stop, Continuous, Dir, Div,
    input  Aout, Bout, Zout, Busy, Pos, RevDone
  );

  modport slave (
    input  Start, Stop, Continuous, Dir, Div,
    output Aout, Bout, Zout, Busy, Pos, RevDone
  );
endinterface

// File: rtl/quad_encoder_sim.sv
// Incremental encoder simulator: quadrature A/B plus Z index at a programmable
// step rate, forward or reverse, single revolution or continuous until stopped.
module quad_encoder_sim #(
  parameter int PPR   = 2048,
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic              Clk,
  input  logic              nRst,
  quad_encoder_sim_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] POS_MAX   = CNT_W'(PPR - 1);
  localparam logic [CNT_W-1:0] POS_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] POS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] TMR_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] TMR_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_q, w_q_nxt, w_q_step;
  logic [DIV_W-1:0] r_timer, w_timer_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [CNT_W-1:0] r_pos, w_pos_nxt, w_pos_step;
  logic             r_dir, w_dir_nxt;
  logic             r_start_prev, w_start_evt, w_index;
  logic             r_a, r_b, r_z, r_busy, r_rev_done;
  logic             w_a_nxt, w_b_nxt, w_z_nxt, w_busy_nxt, w_rev_nxt;
  logic [1:0]       w_ab_step;

  // Gray-coded AB pattern for each quadrature index (A leads B going forward)
  function automatic logic [1:0] ab_decode(input logic [1:0] q);
    case (q)
      2'd0:    ab_decode = 2'b00;
      2'd1:    ab_decode = 2'b10;
      2'd2:    ab_decode = 2'b11;
      2'd3:    ab_decode = 2'b01;
      default: ab_decode = 2'b00;
    endcase
  endfunction

  // Quadrature index and position after one step in the latched direction
  always_comb begin
    w_q_step   = r_q;
    w_pos_step = r_pos;
    if (r_dir == 1'b0) begin
      w_q_step = r_q + 2'd1;
      if (r_q == 2'd3) begin
        if (r_pos == POS_MAX) begin
          w_pos_step = POS_ZERO;
        end else begin
          w_pos_step = r_pos + POS_ONE;
        end
      end else begin
        w_pos_step = r_pos;
      end
    end else begin
      w_q_step = r_q - 2'd1;
      if (r_q == 2'd0) begin
        if (r_pos == POS_ZERO) begin
          w_pos_step = POS_MAX;
        end else begin
          w_pos_step = r_pos - POS_ONE;
        end
      end else begin
        w_pos_step = r_pos;
      end
    end
    w_index   = (w_pos_step == POS_ZERO) && (w_q_step == 2'd0);
    w_ab_step = ab_decode(w_q_step);
  end

  // Next-state and registered-output logic for the IDLE/RUN controller
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_timer_nxt = r_timer;
    w_pos_nxt   = r_pos;
    w_div_nxt   = r_div;
    w_dir_nxt   = r_dir;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_z_nxt     = r_z;
    w_busy_nxt  = r_busy;
    w_rev_nxt   = 1'b0;
    w_start_evt = bus.Start & ~r_start_prev;

    case (r_state)
      ST_IDLE: begin
        if (w_start_evt && !bus.Stop) begin
          w_state_nxt = ST_RUN;
          w_q_nxt     = 2'd0;
          w_timer_nxt = TMR_ZERO;
          w_pos_nxt   = POS_ZERO;
          w_div_nxt   = bus.Div;
          w_dir_nxt   = bus.Dir;
          w_a_nxt     = 1'b0;
          w_b_nxt     = 1'b0;
          w_z_nxt     = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_a_nxt    = 1'b0;
          w_b_nxt    = 1'b0;
          w_z_nxt    = 1'b0;
          w_busy_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        // A single run ends on the edge right after its RevDone cycle
        if (bus.Stop || (r_rev_done && !bus.Continuous)) begin
          w_state_nxt = ST_IDLE;
          w_a_nxt     = 1'b0;
          w_b_nxt     = 1'b0;
          w_z_nxt     = 1'b0;
          w_busy_nxt  = 1'b0;
        end else if (r_timer == r_div) begin
          w_timer_nxt = TMR_ZERO;
          w_q_nxt     = w_q_step;
          w_pos_nxt   = w_pos_step;
          w_a_nxt     = w_ab_step[1];
          w_b_nxt     = w_ab_step[0];
          w_z_nxt     = w_index;
          w_rev_nxt   = w_index;
        end else begin
          w_timer_nxt = r_timer + TMR_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_a_nxt     = 1'b0;
        w_b_nxt     = 1'b0;
        w_z_nxt     = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= ST_IDLE;
      r_q          <= 2'd0;
      r_timer      <= TMR_ZERO;
      r_pos        <= POS_ZERO;
      r_div        <= TMR_ZERO;
      r_dir        <= 1'b0;
      r_start_prev <= 1'b0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_z          <= 1'b0;
      r_busy       <= 1'b0;
      r_rev_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_q          <= w_q_nxt;
      r_timer      <= w_timer_nxt;
      r_pos        <= w_pos_nxt;
      r_div        <= w_div_nxt;
      r_dir        <= w_dir_nxt;
      r_start_prev <= bus.Start;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_z          <= w_z_nxt;
      r_busy       <= w_busy_nxt;
      r_rev_done   <= w_rev_nxt;
    end
  end

  assign bus.Aout    = r_a;
  assign bus.Bout    = r_b;
  assign bus.Zout    = r_z;
  assign bus.Busy    = r_busy;
  assign bus.Pos     = r_pos;
  assign bus.RevDone = r_rev_done;

endmodule

// File: tb/tb_quad_encoder_sim.sv
// Self-checking bench for quad_encoder_sim: table-driven runs, hand-written corner
// sequences and random stimulus against a quarter-count reference model.
module tb_quad_encoder_sim;
  localparam int PPR   = 4;
  localparam int CNT_W = 4;
  localparam int DIV_W = 16;
  localparam int QPR   = 4 * PPR;

  logic Clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 Clk = ~Clk;

  quad_encoder_sim_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();
  quad_encoder_sim #(.PPR(PPR), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .Clk(Clk), .nRst(nRst), .bus(bus)
  );

  quad_encoder_sim_if #(.CNT_W(16), .DIV_W(16)) bus2 ();
  quad_encoder_sim #(.PPR(2048), .CNT_W(16), .DIV_W(16)) dut2 (
    .Clk(Clk), .nRst(nRst), .bus(bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rev_seen = 0;

  // Reference model: the run is a linear count of quarter steps since the start edge
  bit m_run = 1'b0, m_sp = 1'b0, m_rev_prev = 1'b0, m_dir = 1'b0;
  int m_k = 0, m_div = 0, m_pos_hold = 0;
  logic [3:0] a_tab = 4'b0110;
  logic [3:0] b_tab = 4'b1100;

  typedef struct {
    bit dir; int div; bit cont; int ncyc;
    int exp_revs; bit exp_busy; int exp_pos;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_sp = 1'b0; m_rev_prev = 1'b0; m_k = 0; m_pos_hold = 0;
  endtask

  task automatic model_edge();
    bit evt;
    evt  = bus.Start && !m_sp;
    m_sp = bus.Start;
    if (!m_run) begin
      if (evt && !bus.Stop) begin
        m_run = 1'b1; m_k = 0; m_div = int'(bus.Div); m_dir = bus.Dir;
      end
    end else if (bus.Stop || (m_rev_prev && !bus.Continuous)) begin
      m_run = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  // One clock edge of the main DUT, compared against the model #1 later
  task automatic cycle();
    logic ea, eb, ez, ebusy, erev;
    int s, p, q, epos;
    logic [CNT_W+4:0] act, exp;
    @(posedge Clk);
    model_edge();
    if (m_run) begin
      s = m_k / (m_div + 1);
      p = s % QPR;
      if (m_dir) p = (QPR - p) % QPR;
      q = p % 4;
      epos  = p / 4;
      ea    = a_tab[q];
      eb    = b_tab[q];
      ez    = (p == 0);
      ebusy = 1'b1;
      erev  = (m_k > 0) && (m_k % (m_div + 1) == 0) && (p == 0);
      m_pos_hold = epos;
    end else begin
      ea = 1'b0; eb = 1'b0; ez = 1'b0; ebusy = 1'b0; erev = 1'b0;
      epos = m_pos_hold;
    end
    m_rev_prev = erev;
    #1;
    act = {bus.Aout, bus.Bout, bus.Zout, bus.Busy, bus.RevDone, bus.Pos};
    exp = {ea, eb, ez, ebusy, erev, CNT_W'(epos)};
    check("cycle{A,B,Z,Busy,RevDone,Pos}", act, exp);
    if (bus.RevDone) rev_seen++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int z2, r2, rev_k, pos_before;
    tbl[0] = '{dir: 1'b0, div: 1, cont: 1'b0, ncyc: 40, exp_revs: 1, exp_busy: 1'b0, exp_pos: 0};
    tbl[1] = '{dir: 1'b1, div: 1, cont: 1'b0, ncyc: 20, exp_revs: 0, exp_busy: 1'b1, exp_pos: 1};
    tbl[2] = '{dir: 1'b1, div: 1, cont: 1'b0, ncyc: 40, exp_revs: 1, exp_busy: 1'b0, exp_pos: 0};
    tbl[3] = '{dir: 1'b0, div: 0, cont: 1'b1, ncyc: 48, exp_revs: 3, exp_busy: 1'b1, exp_pos: 0};
    tbl[4] = '{dir: 1'b0, div: 0, cont: 1'b1, ncyc: 53, exp_revs: 3, exp_busy: 1'b1, exp_pos: 1};
    tbl[5] = '{dir: 1'b0, div: 2, cont: 1'b0, ncyc: 13, exp_revs: 0, exp_busy: 1'b1, exp_pos: 1};
    tbl[6] = '{dir: 1'b1, div: 0, cont: 1'b0, ncyc: 7,  exp_revs: 0, exp_busy: 1'b1, exp_pos: 2};
    tbl[7] = '{dir: 1'b0, div: 3, cont: 1'b0, ncyc: 64, exp_revs: 1, exp_busy: 1'b1, exp_pos: 0};
    tbl[8] = '{dir: 1'b1, div: 0, cont: 1'b1, ncyc: 35, exp_revs: 2, exp_busy: 1'b1, exp_pos: 3};

    bus.Start = 1'b0; bus.Stop = 1'b0; bus.Continuous = 1'b0; bus.Dir = 1'b0; bus.Div = 16'd1;
    bus2.Start = 1'b0; bus2.Stop = 1'b0; bus2.Continuous = 1'b0; bus2.Dir = 1'b0; bus2.Div = 16'd0;
    #2;
    check("reset_outputs", {bus.Aout, bus.Bout, bus.Zout, bus.Busy, bus.RevDone, bus.Pos}, 0);
    check("reset_outputs_w16", {bus2.Aout, bus2.Bout, bus2.Zout, bus2.Busy, bus2.RevDone, bus2.Pos}, 0);
    @(posedge Clk); #1 nRst = 1'b1;
    model_reset();
    repeat (2) cycle();

    // Table of runs started from IDLE, each closed with a Stop
    for (int i = 0; i < 9; i++) begin
      bus.Dir = tbl[i].dir; bus.Div = DIV_W'(tbl[i].div); bus.Continuous = tbl[i].cont;
      bus.Start = 1'b1; rev_seen = 0;
      cycle();
      bus.Start = 1'b0;
      repeat (tbl[i].ncyc) cycle();
      check($sformatf("vec%0d_revs", i), rev_seen, tbl[i].exp_revs);
      check($sformatf("vec%0d_busy", i), bus.Busy, tbl[i].exp_busy);
      check($sformatf("vec%0d_pos", i), bus.Pos, tbl[i].exp_pos);
      bus.Stop = 1'b1; cycle();
      check($sformatf("vec%0d_pos_after_stop", i), bus.Pos, tbl[i].exp_pos);
      bus.Stop = 1'b0; cycle();
    end

    // Start held high for 40+ cycles gives exactly one single-mode run
    bus.Dir = 1'b0; bus.Div = 16'd1; bus.Continuous = 1'b0; bus.Start = 1'b1; rev_seen = 0;
    repeat (41) cycle();
    bus.Start = 1'b0; cycle();
    check("held_start_revs", rev_seen, 1);
    check("held_start_busy", bus.Busy, 0);

    // Start edge together with Stop does not start a run
    bus.Start = 1'b1; bus.Stop = 1'b1; cycle();
    bus.Start = 1'b0; bus.Stop = 1'b0; cycle();
    check("start_with_stop_busy", bus.Busy, 0);

    // Restart attempt plus Dir/Div change mid-run leave the run untouched
    bus.Dir = 1'b0; bus.Div = 16'd1; bus.Start = 1'b1; rev_seen = 0;
    cycle();
    bus.Start = 1'b0;
    repeat (9) cycle();
    bus.Start = 1'b1; bus.Dir = 1'b1; bus.Div = 16'd3;
    cycle();
    check("restart_ignored_pos", bus.Pos, 1);
    bus.Start = 1'b0;
    repeat (22) cycle();
    check("latched_rev_at_32", bus.RevDone, 1);
    repeat (8) cycle();
    check("latched_revs", rev_seen, 1);
    check("latched_busy", bus.Busy, 0);

    // Asynchronous reset in the middle of a continuous run
    bus.Dir = 1'b0; bus.Div = 16'd1; bus.Continuous = 1'b1; bus.Start = 1'b1;
    cycle();
    bus.Start = 1'b0;
    repeat (12) cycle();
    #2 nRst = 1'b0;
    #1;
    check("async_reset_outputs", {bus.Aout, bus.Bout, bus.Zout, bus.Busy, bus.RevDone, bus.Pos}, 0);
    model_reset();
    @(posedge Clk);
    @(posedge Clk); #1 nRst = 1'b1;
    repeat (3) cycle();
    check("after_reset_idle", bus.Busy, 0);

    // Wide counter: PPR=2048, Div=0, continuous
    bus2.Div = 16'd0; bus2.Continuous = 1'b1; bus2.Dir = 1'b0; bus2.Start = 1'b1;
    z2 = 0; r2 = 0; rev_k = -1; pos_before = -1;
    @(posedge Clk); #1 bus2.Start = 1'b0;
    for (int k = 0; k <= 8192; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if (bus2.Zout) z2++;
      if (bus2.RevDone) begin r2++; if (rev_k < 0) rev_k = k; end
      if (k == 8191) pos_before = int'(bus2.Pos);
    end
    check("w16_pos_before_wrap", pos_before, 2047);
    check("w16_pos_after_wrap", bus2.Pos, 0);
    check("w16_rev_cycle", rev_k, 8192);
    check("w16_rev_count", r2, 1);
    check("w16_z_count", z2, 2);
    bus2.Stop = 1'b1;
    @(posedge Clk); #1;
    check("w16_stop_busy", bus2.Busy, 0);
    bus2.Stop = 1'b0;

    // Random control traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.Start      = ($urandom_range(0, 3) == 0);
      bus.Stop       = ($urandom_range(0, 49) == 0);
      bus.Dir        = 1'($urandom_range(0, 1));
      bus.Div        = DIV_W'($urandom_range(0, 3));
      bus.Continuous = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
